// File: rtl/line_window_buffer.sv
// line_window_buffer: stores KERNEL_H-1 image lines and presents one
// KERNEL_H-tall pixel column per accepted raster pixel to the column core.
// Ports: i_clk, i_rst (sync, active high); i_valid/o_ready/i_pixel upstream;
// i_ready downstream; o_vector column ([0] oldest line, top = i_pixel);
// o_pipe_en core advance; o_out_valid core result valid;
// o_frame_done one-cycle pulse after the last flush advance.
module line_window_buffer #(
  parameter int DATA_W   = 8,
  parameter int KERNEL_H = 7,
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int CORE_LAT = 3
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [DATA_W-1:0]                i_pixel,
  input  logic                             i_ready,
  output logic [KERNEL_H-1:0][DATA_W-1:0]  o_vector,
  output logic                             o_pipe_en,
  output logic                             o_out_valid,
  output logic                             o_frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(CORE_LAT) + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILL = RW'(KERNEL_H - 2);
  localparam logic [RW-1:0] ROW_WIN  = RW'(KERNEL_H - 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    FILL,
    STREAM,
    FLUSH
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [FW-1:0]       flush_cnt;
  logic [CORE_LAT-1:0] vld;

  logic [DATA_W-1:0] mem [KERNEL_H-1][IMG_W];

  logic accept;
  logic in_flush;
  logic col_end;
  logic row_end;
  logic flush_end;
  logic window_valid;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= FILL;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      FILL: begin
        if (accept && col_end && row == ROW_FILL)
          state_nx = STREAM;
      end
      STREAM: begin
        if (accept && col_end && row_end)
          state_nx = FLUSH;
      end
      FLUSH: begin
        if (flush_end)
          state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // FSM outputs: flush advances the core on i_ready alone
  always_comb begin
    in_flush  = 1'b0;
    o_ready   = i_ready;
    o_pipe_en = i_valid && i_ready;
    unique case (state)
      FLUSH: begin
        in_flush  = 1'b1;
        o_ready   = 1'b0;
        o_pipe_en = i_ready;
      end
      default: ;
    endcase
  end

  assign accept       = i_valid && o_ready;
  assign col_end      = (col == COL_LAST);
  assign row_end      = (row == ROW_LAST);
  assign flush_end    = in_flush && o_pipe_en
                     && (flush_cnt == FL_LAST);
  assign window_valid = accept && (row >= ROW_WIN);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // tags travel alongside the core's pipeline
  always_ff @(posedge i_clk) begin
    if (i_rst)          vld <= '0;
    else if (o_pipe_en) vld <= {vld[CORE_LAT-2:0], window_valid};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)          flush_cnt <= '0;
    else if (!in_flush) flush_cnt <= '0;
    else if (o_pipe_en) flush_cnt <= flush_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_frame_done <= 1'b0;
    else       o_frame_done <= flush_end;
  end

  // column shift: each line moves one slot older, newest pixel on top;
  // the same-cycle read below sees the pre-write contents
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int k = 0; k < KERNEL_H - 2; k++)
        mem[k][col] <= mem[k+1][col];
      mem[KERNEL_H-2][col] <= i_pixel;
    end
  end

  always_comb begin
    o_vector = '0;
    for (int k = 0; k < KERNEL_H - 1; k++)
      o_vector[k] = mem[k][col];
    o_vector[KERNEL_H-1] = i_pixel;
  end

  assign o_out_valid = vld[CORE_LAT-1];

endmodule

// File: tb/tb_line_window_buffer.sv
// tb_line_window_buffer: directed bench for line_window_buffer on an
// 8x8 image, modelling the 3-stage core to check window results per beat.
module tb_line_window_buffer;

  localparam int DW = 8;
  localparam int KH = 7;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int CL = 3;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_valid;
  logic              o_ready;
  logic [DW-1:0]     i_pixel;
  logic              i_ready;
  logic [KH-1:0][DW-1:0] o_vector;
  logic              o_pipe_en;
  logic              o_out_valid;
  logic              o_frame_done;

  line_window_buffer #(
    .DATA_W  (DW),
    .KERNEL_H(KH),
    .IMG_W   (W),
    .IMG_H   (H),
    .CORE_LAT(CL)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_pixel     (i_pixel),
    .i_ready     (i_ready),
    .o_vector    (o_vector),
    .o_pipe_en   (o_pipe_en),
    .o_out_valid (o_out_valid),
    .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  logic [63:0] s0, s1, s2;
  int  beat;
  int  p;
  int  base;
  bit  flushing;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // window ending at raster index idx: rows r-6..r of column c
  function automatic logic [63:0] win(int b, int idx);
    logic [63:0] v;
    int r;
    int c;
    v = '0;
    r = idx / W;
    c = idx % W;
    for (int k = 0; k < KH; k++)
      v[k*8 +: 8] = 8'(b + (r - 6 + k) * W + c);
    return v;
  endfunction

  task automatic observe();
    bit acc;
    acc = i_valid && o_ready;
    if (!i_ready) check("stall_pe", {63'd0, o_pipe_en}, 64'd0);
    if (!flushing)
      check("pe_acc", {63'd0, o_pipe_en}, {63'd0, acc});
    if (acc && p >= 48)
      check("vector", {8'd0, o_vector}, win(base, p));
    if (acc && !flushing && p < 51)
      check("ov_early", {63'd0, o_out_valid}, 64'd0);
    if (o_pipe_en && o_out_valid) begin
      if (!flushing) check("beat_pos", 64'(p), 64'(51 + beat));
      check("beat_data", s2, win(base, 48 + beat));
      beat++;
    end
    if (o_pipe_en) begin
      s2 = s1;
      s1 = s0;
      s0 = {8'd0, o_vector};
    end
    if (acc) p++;
  endtask

  task automatic cycle(bit v, bit r, int px);
    @(negedge i_clk);
    i_valid = v;
    i_ready = r;
    i_pixel = 8'(px);
    #1;
    observe();
  endtask

  // mode 0 continuous, 1 toggle i_ready, 2 random i_valid gaps;
  // stop_at >= 0 pulses reset when that pixel is presented
  task automatic run_frame(int b, int mode, int stop_at);
    bit tog;
    bit v;
    bit r;
    int cyc;
    int pe;
    base = b;
    p = 0;
    beat = 0;
    flushing = 0;
    s0 = '0;
    s1 = '0;
    s2 = '0;
    tog = 1'b1;
    cyc = 0;
    cycle(0, 1, 0);
    check("done_low", {63'd0, o_frame_done}, 64'd0);
    while (p < W * H && p != stop_at && cyc < 2000) begin
      v = 1'b1;
      r = 1'b1;
      if (mode == 1) begin
        r = tog;
        tog = !tog;
      end
      if (mode == 2) v = ($urandom_range(0, 3) != 0);
      cycle(v, r, b + p);
      cyc++;
    end
    if (stop_at >= 0) begin
      check("stop_pos", 64'(p), 64'(stop_at));
      @(negedge i_clk);
      i_rst = 1'b1;
      i_valid = 1'b1;
      i_pixel = 8'(b + p);
      @(negedge i_clk);
      i_rst = 1'b0;
      i_valid = 1'b0;
      return;
    end
    check("pix_accepted", 64'(p), 64'(W * H));
    flushing = 1;
    pe = 0;
    cyc = 0;
    while (pe < CL && cyc < 50) begin
      r = 1'b1;
      if (mode == 1) begin
        r = tog;
        tog = !tog;
      end
      cycle(1, r, b);
      check("flush_rdy", {63'd0, o_ready}, 64'd0);
      if (o_pipe_en) pe++;
      cyc++;
    end
    check("flush_pe", 64'(pe), 64'(CL));
    cycle(0, 1, 0);
    check("frame_done", {63'd0, o_frame_done}, 64'd1);
    check("fill_rdy", {63'd0, o_ready}, 64'd1);
    check("beats", 64'(beat), 64'd16);
    flushing = 0;
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_pixel = '0;
    flushing = 0;
    p = 0;
    beat = 0;
    base = 0;
    s0 = '0;
    s1 = '0;
    s2 = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_ov", {63'd0, o_out_valid}, 64'd0);
    check("rst_done", {63'd0, o_frame_done}, 64'd0);
    check("rst_rdy", {63'd0, o_ready}, 64'd1);
    check("rst_pe0", {63'd0, o_pipe_en}, 64'd0);
    i_valid = 1'b1;
    i_ready = 1'b0;
    #1;
    check("rst_rdy0", {63'd0, o_ready}, 64'd0);
    check("rst_pe_nr", {63'd0, o_pipe_en}, 64'd0);
    i_ready = 1'b1;
    #1;
    check("rst_pe1", {63'd0, o_pipe_en}, 64'd1);
    i_valid = 1'b0;

    run_frame(0, 0, -1);
    run_frame(0, 1, -1);
    run_frame(0, 2, -1);
    run_frame(0, 0, 52);
    run_frame(100, 0, -1);
    run_frame(0, 0, -1);
    run_frame(0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
# line_window_buffer

Vertical window generator sitting directly upstream of the distributed-arithmetic column convolution core. It accepts a raster-order pixel stream, stores the previous KERNEL_H-1 image lines, and presents one KERNEL_H-tall pixel column per accepted pixel together with the core's pipeline enable. It tracks which core outputs correspond to fully-populated windows, and drains the core's 3-stage pipeline at end of frame.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits.
- KERNEL_H, 7, window height; line storage is KERNEL_H-1 lines.
- IMG_W, 64, pixels per line (>= 4).
- IMG_H, 64, lines per frame (>= KERNEL_H).
- CORE_LAT, 3, number of core pipeline-enable advances from vector capture to valid core output.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream pixel valid.
- o_ready  out  1  block can accept a pixel this cycle.
- i_pixel  in  DATA_W  unsigned pixel, raster order.
- i_ready  in  1  downstream can take a core output this cycle.
- o_vector  out  KERNEL_H x DATA_W  column window to core; [0] = oldest line (row r-KERNEL_H+1), [KERNEL_H-1] = i_pixel.
- o_pipe_en  out  1  core pipeline advance (drives core i_pipe_en).
- o_out_valid  out  1  core o_data currently holds a valid window result.
- o_frame_done  out  1  one-cycle pulse after the final flush advance of a frame.

## Operation
- Accept = i_valid && o_ready. o_ready = i_ready in FILL/STREAM, 0 in FLUSH.
- o_pipe_en = accept in FILL/STREAM; = i_ready in FLUSH.
- Line memory mem[0..KERNEL_H-2][0..IMG_W-1], no reset. On accept at column c: mem[k][c] <= mem[k+1][c] for k < KERNEL_H-2; mem[KERNEL_H-2][c] <= i_pixel.
- o_vector combinational: o_vector[k] = mem[k][col] for k < KERNEL_H-1; o_vector[KERNEL_H-1] = i_pixel.
- Counters col (0..IMG_W-1), row (0..IMG_H-1) advance on accept; col wraps to 0 and increments row; row wraps to 0 at frame end.
- window_valid = accept && (row >= KERNEL_H-1).
- Valid shift register vld[0..CORE_LAT-1] shifts on o_pipe_en: vld[0] <= window_valid (0 in FLUSH). o_out_valid = vld[CORE_LAT-1].
- Output beat = cycle with o_pipe_en && o_out_valid; the consumer samples core o_data in that cycle. Outputs per frame = (IMG_H-KERNEL_H+1)*IMG_W.
- FSM:
  - FILL: row < KERNEL_H-1. When accepting col IMG_W-1 of row KERNEL_H-2, go to STREAM.
  - STREAM: when accepting (IMG_W-1, IMG_H-1), go to FLUSH with flush_cnt = 0.
  - FLUSH: each o_pipe_en increments flush_cnt; on the CORE_LAT-th advance, go to FILL and register o_frame_done = 1 for the next cycle.
- Stall: with i_ready = 0, nothing advances. Counters, vld, and memory hold, and o_vector follows i_pixel only.

## Timing
- Reset values: state FILL, col = row = 0, vld all 0, flush_cnt = 0, o_out_valid = 0, o_frame_done = 0. o_ready = i_ready and o_pipe_en = i_valid && i_ready immediately after reset.
- Reset mid-frame: on the next cycle, counters, FSM, and vld return to reset values. Stale line memory is never marked valid because FILL refills all KERNEL_H-1 lines. The core shares i_rst.
- Latency: a window accepted on advance N reaches o_out_valid after advance N+CORE_LAT-1. It is sampled on advance N+CORE_LAT.
- The memory write and the combinational read of the same column in the same cycle use pre-write data. This is required so the column shift is correct.
- Frame back-to-back: a new frame's first pixel is accepted no earlier than the cycle after the last FLUSH advance. o_frame_done and that accept may coincide.
- The FLUSH advance count is independent of i_valid. i_valid during FLUSH is ignored and not consumed.

## Test plan
- Use IMG_W = 8, IMG_H = 8, and pixel = (row*8 + col) mod 256 in all scenarios.
- Basic fill: continuous valid, i_ready = 1.
  - On accept of (6,0): o_vector = {0, 8, 16, 24, 32, 40, 48}.
  - First o_out_valid beat on accept of (6,3).
  - 16 beats per frame total.
- Flush: after accept of (7,7), expect o_ready = 0 for 3 cycles, 3 o_pipe_en pulses, the last 3 beats valid, then o_frame_done = 1 for one cycle and state FILL.
- Backpressure: toggle i_ready 1/0 every cycle with i_valid = 1.
  - Same 16 window results in order.
  - No o_pipe_en while i_ready = 0.
  - col/row unchanged across stalls.
- Bubbles: random i_valid gaps with i_ready = 1. Expect o_pipe_en only on accepts, and the beat sequence identical to the basic-fill scenario.
- Mid-frame reset: assert i_rst at (6,4) for one cycle, then restart the frame with pixel + 100.
  - o_out_valid stays 0 until the 4th accept of new row 6.
  - First new window = {100, 108, ..., 148}.
- Two back-to-back frames: the second frame produces 16 beats with correct columns. No beat during the second frame's FILL rows 0–5.
